conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream.sv | 186 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution over raster pixels, valid-window output only.
// Two-stage pipeline: per-tap multiply, then sum / shift / clamp.
module conv3x3_stream #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 540,
    parameter int IMAGE_HEIGHT = 360,
    parameter int COEF_WIDTH   = 8,
    parameter int SHIFT        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WORD_SIZE-1:0]  inputPixel,
    input  logic                  coef_we,
    input  logic [3:0]            coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    input  logic                  mode,
    output logic                  out_valid,
    output logic [WORD_SIZE-1:0]  outputPixel,
    output logic                  frame_done
);

    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int PW = WORD_SIZE + COEF_WIDTH + 1;
    localparam int AW = WORD_SIZE + COEF_WIDTH + 5;
    localparam logic signed [COEF_WIDTH-1:0] ONE = COEF_WIDTH'(1 << SHIFT);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            frame_done_q, frame_done_d;
    logic            load_coef;
    logic            accept, col_last, row_last, win_ok;

    assign accept   = in_valid & ~rst;
    assign col_last = (col_q == CW'(ROW_SIZE - 1));
    assign row_last = (row_q == RW'(IMAGE_HEIGHT - 1));
    assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        load_coef    = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    state_d   = ACTIVE;
                    load_coef = 1'b1;
                end
                ACTIVE: begin
                    if (col_last && row_last) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Staging set is writable anytime; active set only changes at frame start.
    logic signed [COEF_WIDTH-1:0] stg_q [9];
    logic signed [COEF_WIDTH-1:0] act_q [9];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                stg_q[k] <= (k == 4) ? ONE : '0;
                act_q[k] <= (k == 4) ? ONE : '0;
            end
        end else begin
            if (load_coef) act_q <= stg_q;
            if (coef_we && coef_addr < 4'd9) stg_q[coef_addr] <= $signed(coef_data);
        end
    end

    logic [WORD_SIZE-1:0] lb0_q [ROW_SIZE];
    logic [WORD_SIZE-1:0] lb1_q [ROW_SIZE];
    logic [WORD_SIZE-1:0] win_q [3][2];
    logic [WORD_SIZE-1:0] col_n [3];
    logic [WORD_SIZE-1:0] tap   [9];

    assign col_n[0] = lb1_q[col_q];
    assign col_n[1] = lb0_q[col_q];
    assign col_n[2] = inputPixel;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= inputPixel;
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= col_n[i];
            end
        end
    end

    // Window seen by the multiplier includes the column being accepted now.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap[3*i]   = win_q[i][0];
            tap[3*i+1] = win_q[i][1];
            tap[3*i+2] = col_n[i];
        end
    end

    function automatic logic signed [PW-1:0] mul(
        input logic [WORD_SIZE-1:0]         p,
        input logic signed [COEF_WIDTH-1:0] c
    );
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = PW'($signed({1'b0, p}));
        b = PW'(c);
        return a * b;
    endfunction

    logic signed [PW-1:0] prod_d [9];
    logic signed [PW-1:0] prod_q [9];
    logic                 v1_q, m1_q;

    always_comb begin
        for (int k = 0; k < 9; k++) prod_d[k] = mul(tap[k], act_q[k]);
    end

    always_ff @(posedge clk) begin
        if (accept && win_ok) begin
            prod_q <= prod_d;
            m1_q   <= mode;
        end
    end

    logic signed [AW-1:0] sum, shd;
    logic [WORD_SIZE-1:0] res;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) sum = sum + AW'(prod_q[k]);
        shd = sum >>> SHIFT;
        if (m1_q && shd[AW-1]) shd = -shd;
        res = shd[WORD_SIZE-1:0];
        if (shd[AW-1]) res = '0;
        else if (|shd[AW-2:WORD_SIZE]) res = '1;
    end

    logic                 out_valid_q;
    logic [WORD_SIZE-1:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            v1_q        <= accept && win_ok;
            out_valid_q <= v1_q;
            if (v1_q) out_q <= res;
        end
    end

    assign out_valid   = out_valid_q;
    assign outputPixel = out_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomized bench for conv3x3_stream against a frame-level reference model.
// Expected outputs are scheduled by cycle and compared every cycle.
module tb_conv3x3_stream;

    localparam int RS = 4;
    localparam int IH = 4;
    localparam int SH = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, coef_we, mode;
    logic [7:0] inputPixel, coef_data;
    logic [3:0] coef_addr;
    logic       out_valid, frame_done;
    logic [7:0] outputPixel;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .WORD_SIZE(8), .ROW_SIZE(RS), .IMAGE_HEIGHT(IH),
        .COEF_WIDTH(8), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inputPixel(inputPixel),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mode(mode), .out_valid(out_valid), .outputPixel(outputPixel),
        .frame_done(frame_done)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_px [int];
    bit exp_fd [int];
    int img [IH][RS];
    int stg [9];
    int act [9];
    int nk  [9];
    int mr = 0;
    int mc = 0;
    int last_px = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                      tag, got, want, cyc);
    endtask

    function automatic int ref_pixel(int r, int c, logic m);
        int s, q, d;
        s = 0;
        d = 1 << SH;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += act[3*i+j] * img[r-2+i][c-2+j];
        q = (s >= 0) ? s / d : -((-s + d - 1) / d);
        if (m && q < 0) q = -q;
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_px.exists(cyc)) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("pixel", 32'(outputPixel), exp_px[cyc]);
            last_px = exp_px[cyc];
        end else begin
            check("out_valid", 32'(out_valid), 32'd0);
            check("hold", 32'(outputPixel), last_px);
        end
        check("frame_done", 32'(frame_done), exp_fd.exists(cyc) ? 32'd1 : 32'd0);
    endtask

    task automatic drive(input logic r, input logic v, input int p,
                         input logic we, input int a, input int d,
                         input logic m);
        rst        = r;
        in_valid   = v;
        inputPixel = 8'(p);
        coef_we    = we;
        coef_addr  = 4'(a);
        coef_data  = 8'(d);
        mode       = m;
        if (r) begin
            exp_px.delete();
            exp_fd.delete();
            mr = 0;
            mc = 0;
            for (int k = 0; k < 9; k++) begin
                stg[k] = (k == 4) ? 16 : 0;
                act[k] = stg[k];
            end
            last_px = 0;
        end else begin
            if (v) begin
                if (mr == 0 && mc == 0) act = stg;
                img[mr][mc] = p;
                if (mr >= 2 && mc >= 2) exp_px[cyc+2] = ref_pixel(mr, mc, m);
                if (mr == IH-1 && mc == RS-1) exp_fd[cyc+1] = 1'b1;
                mc++;
                if (mc == RS) begin
                    mc = 0;
                    mr = (mr == IH-1) ? 0 : mr + 1;
                end
            end
            if (we && a < 9) stg[a] = d;
        end
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, int'($urandom_range(255, 0)), 1'b0, 0, 0, 1'b0);
    endtask

    task automatic write_kernel();
        for (int k = 0; k < 9; k++) drive(1'b0, 1'b0, 0, 1'b1, k, nk[k], 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, int'($urandom_range(15, 9)),
              int'($urandom_range(255, 0)) - 128, 1'b0);
    endtask

    // kind: 0 ramp, 1 constant, 2 random pixels with random mode
    task automatic send_frame(input int kind, input int cval, input logic m,
                              input int max_gap, input int wr_at,
                              input int abort_at);
        int pix;
        logic pm;
        for (int idx = 0; idx < RS*IH; idx++) begin
            if (idx == wr_at) write_kernel();
            repeat (int'($urandom_range(max_gap, 0))) idle();
            pix = (kind == 0) ? 4*(idx/RS) + idx%RS :
                  (kind == 1) ? cval : int'($urandom_range(255, 0));
            pm = (kind == 2) ? 1'($urandom_range(1, 0)) : m;
            if (idx == abort_at) begin
                drive(1'b1, 1'b1, pix, 1'b1, 0, 5, pm);
                repeat (3) idle();
                return;
            end
            drive(1'b0, 1'b1, pix, 1'b0, 0, 0, pm);
        end
        repeat (4) idle();
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < 9; k++) nk[k] = v;
    endtask

    task automatic set_rand();
        for (int k = 0; k < 9; k++) nk[k] = int'($urandom_range(255, 0)) - 128;
    endtask

    initial begin
        repeat (3) drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);

        send_frame(0, 0, 1'b0, 0, -1, -1);

        set_all(1);
        write_kernel();
        send_frame(1, 32, 1'b0, 0, -1, -1);

        set_all(16);
        write_kernel();
        send_frame(1, 255, 1'b0, 0, -1, -1);

        set_all(0);
        nk[4] = -16;
        write_kernel();
        send_frame(1, 100, 1'b0, 0, -1, -1);
        send_frame(1, 100, 1'b1, 0, -1, -1);

        set_all(0);
        nk[4] = 16;
        write_kernel();
        send_frame(0, 0, 1'b0, 3, -1, -1);

        for (int f = 0; f < 3; f++) begin
            set_rand();
            write_kernel();
            send_frame(2, 0, 1'b0, 3, -1, -1);
        end

        set_rand();
        write_kernel();
        set_rand();
        send_frame(2, 0, 1'b0, 1, 5, -1);
        send_frame(2, 0, 1'b0, 2, -1, -1);

        send_frame(0, 0, 1'b0, 1, -1, 9);
        send_frame(0, 0, 1'b0, 0, -1, -1);
        send_frame(2, 0, 1'b0, 3, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
